if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
//  Holds the PC and issues single-outstanding requests to instruction memory
//  (req/gnt, then rvalid). Buffers one returned word and loads the IF/ID register.
//  Consumes PCWrite/IF_ID_Write from the hazard detection unit and the EX-stage redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded at reset
//  NOP_INSTR  32'h0000_0000  bubble encoding (sll $0,$0,0)
// PORTS
//  clk            in   1   clock; all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  PCWrite        in   1   0 = do not issue a new fetch (load-use stall)
//  IF_ID_Write    in   1   0 = hold IF/ID contents
//  redirect       in   1   taken branch/jump: flush wrong-path fetch
//  redirect_pc    in   32  target PC (word aligned)
//  imem_req       out  1   fetch request valid
//  imem_addr      out  32  fetch address (= pc while imem_req)
//  imem_gnt       in   1   request accepted this cycle
//  imem_rvalid    in   1   imem_rdata valid (>=1 cycle after gnt)
//  imem_rdata     in   32  returned instruction
//  IF_ID_instr    out  32  instruction to ID
//  IF_ID_pc4      out  32  PC+4 of that instruction
//  IF_ID_valid    out  1   0 = bubble
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=REQ, buf_valid=0, IF_ID_instr=NOP_INSTR,
//   IF_ID_pc4=0, IF_ID_valid=0, imem_req=0. First request in first cycle after release.
//  State: pc, pc_inflight, buf{instr,pc4,valid}, FSM {REQ, RESP, DROP}.
//  REQ : imem_req = PCWrite & (~buf_valid | drain) & ~redirect; imem_addr=pc.
//        drain = IF_ID_Write & buf_valid. On req&gnt: pc_inflight<=pc -> RESP.
//  RESP: imem_req=0. On rvalid: buf<={rdata, pc_inflight+4, 1}; pc<=pc_inflight+4 -> REQ.
//  DROP: imem_req=0. Wait for rvalid of wrong-path request, discard data -> REQ.
//  Exactly one outstanding request; no new req until its rvalid returns.
//  IF/ID update each cycle: redirect -> bubble; else IF_ID_Write=1 -> load buf if
//   buf_valid (then buf_valid<=0 unless refilled same cycle) else bubble;
//   IF_ID_Write=0 -> hold. Bubble = {NOP_INSTR, pc4 unchanged, valid=0}.
//  Latency: gnt cycle N, rvalid cycle M -> buf at M+1 -> IF/ID at M+2 (if IF_ID_Write).
//  Buffer refill and drain in the same cycle allowed (rvalid with drain).
//  Redirect (priority over everything):
//   pc<=redirect_pc; buf_valid<=0; IF/ID<=bubble (overrides IF_ID_Write=0).
//   REQ without gnt -> stay REQ, no req this cycle; REQ with gnt impossible (req masked).
//   RESP w/o rvalid -> DROP; RESP with rvalid -> data discarded, pc not overwritten, -> REQ.
//   DROP + redirect -> pc updated, stay DROP (or REQ if rvalid same cycle).
//  PCWrite=0: only blocks new requests; an in-flight response still lands in buf.
//  PC arithmetic mod 2^32; 32'hFFFF_FFFC+4 wraps to 0. imem_addr[1:0] always 2'b00
//   (redirect_pc[1:0] ignored, forced 0).
//  Reset asserted mid-transaction: state cleared immediately; a late rvalid after
//   reset release while in REQ is ignored (rvalid only observed in RESP/DROP).
// TESTING
//  1 Reset release, gnt same cycle, rvalid +1 with 0x2002_0005 -> imem_addr 0x0,
//    IF_ID_instr=0x2002_0005, IF_ID_pc4=0x4, valid=1 at cycle 3; next req addr 0x4.
//  2 Load-use: PCWrite=0,IF_ID_Write=0 for 1 cycle with buf full -> IF/ID held,
//    no imem_req that cycle, buf delivered next cycle, no instruction lost/duplicated.
//  3 Redirect to 0x0000_0100 while in RESP, rvalid 2 cycles later with 0xDEAD_BEEF ->
//    DROP, data never reaches IF/ID, next imem_addr=0x100, IF_ID_valid=0 meanwhile.
//  4 Redirect same cycle as rvalid in RESP -> data discarded, next req addr=redirect_pc.
//  5 Redirect with IF_ID_Write=0 -> IF/ID becomes bubble (valid=0, NOP_INSTR).
//  6 pc=0xFFFF_FFFC fetch -> IF_ID_pc4=0x0, next imem_addr=0x0; rst_n pulse in RESP
//    -> all outputs at reset values immediately, stray rvalid after release ignored.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: req/gnt handshake, then rvalid with data.
// The fetch stage is the master; the memory (or bench model) is the slave.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage + IF/ID register: single-outstanding imem fetch, one-word return buffer.
// Latency: rvalid cycle M -> buffer at M+1 -> IF/ID at M+2; PCWrite/IF_ID_Write stall, redirect flushes.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     PCWrite,
    input  logic                     IF_ID_Write,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              IF_ID_instr,
    output logic [31:0]              IF_ID_pc4,
    output logic                     IF_ID_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pc_inflight;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc4;
    logic        r_buf_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    logic        w_drain;
    logic        w_req;
    logic        w_fire;
    logic        w_land;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_inflight_pc4;
    logic        w_unused;

    assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
    assign w_unused       = ^redirect_pc[1:0];
    assign w_inflight_pc4 = r_pc_inflight + 32'd4;
    assign w_drain        = IF_ID_Write & r_buf_valid;

    // Reset gates the request so nothing is issued while rst_n is held low.
    assign w_req  = rst_n & (r_state == S_REQ) & PCWrite
                  & (~r_buf_valid | w_drain) & ~redirect;
    assign w_fire = w_req & imem.imem_gnt;
    assign w_land = (r_state == S_RESP) & imem.imem_rvalid & ~redirect;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign IF_ID_instr = r_ifid_instr;
    assign IF_ID_pc4   = r_ifid_pc4;
    assign IF_ID_valid = r_ifid_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_fire) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (imem.imem_rvalid)  w_state_nxt = S_REQ;
                else if (redirect)     w_state_nxt = S_DROP;
            end
            S_DROP: begin
                if (imem.imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_pc_inflight <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) r_pc_inflight <= r_pc;
            if (redirect)    r_pc <= w_redirect_pc;
            else if (w_land) r_pc <= w_inflight_pc4;
        end
    end

    // Return buffer: a landing response may refill it in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_instr <= 32'd0;
            r_buf_pc4   <= 32'd0;
            r_buf_valid <= 1'b0;
        end else if (redirect) begin
            r_buf_valid <= 1'b0;
        end else if (w_land) begin
            r_buf_instr <= imem.imem_rdata;
            r_buf_pc4   <= w_inflight_pc4;
            r_buf_valid <= 1'b1;
        end else if (w_drain) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Bubbles keep pc4 so downstream sees a stable value on invalid slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (redirect) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (IF_ID_Write) begin
            if (r_buf_valid) begin
                r_ifid_instr <= r_buf_instr;
                r_ifid_pc4   <= r_buf_pc4;
                r_ifid_valid <= 1'b1;
            end else begin
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: one continuous instruction stream walked through
// reset, stalls, redirects, PC wrap and mid-transaction reset.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;
    int          checks;
    int          errors;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCWrite     (PCWrite),
        .IF_ID_Write (IF_ID_Write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_pc4   (IF_ID_pc4),
        .IF_ID_valid (IF_ID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are then driven 2ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        PCWrite          = 1'b1;
        IF_ID_Write      = 1'b1;
        redirect         = 1'b0;
        redirect_pc      = 32'd0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem.imem_req); end
        checks++; if (IF_ID_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %08h exp 00000000", IF_ID_instr); end
        checks++; if (IF_ID_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %08h exp 00000000", IF_ID_pc4); end
        checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", IF_ID_valid); end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL t1_req0 got %0h exp 1", imem.imem_req); end
        checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL t1_addr0 got %08h exp 00000000", imem.imem_addr); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL t1_req_resp got %0h exp 0", imem.imem_req); end
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h2002_0005;
        tick();
        imem.imem_rvalid = 1'b0;
        #1;
        checks++; if (imem.imem_addr !== 32'h4 || imem.imem_req !== 1'b1) begin errors++; $display("FAIL t1_next_req got req=%0h addr=%08h exp req=1 addr=00000004", imem.imem_req, imem.imem_addr); end
        checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_early got %0h exp 0", IF_ID_valid); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        #1;
        checks++; if (IF_ID_instr !== 32'h2002_0005) begin errors++; $display("FAIL t1_instr got %08h exp 20020005", IF_ID_instr); end
        checks++; if (IF_ID_pc4 !== 32'h4) begin errors++; $display("FAIL t1_pc4 got %08h exp 00000004", IF_ID_pc4); end
        checks++; if (IF_ID_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0h exp 1", IF_ID_valid); end
    endtask

    task automatic test_load_use();
        // Response for addr 4 lands while IF/ID holds the first instruction.
        IF_ID_Write = 1'b0;
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h1111_1111;
        tick();
        imem.imem_rvalid = 1'b0;
        PCWrite = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL t2_stall_req got %0h exp 0", imem.imem_req); end
        tick();
        #1;
        checks++; if (IF_ID_instr !== 32'h2002_0005 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL t2_hold got %08h v=%0h exp 20020005 v=1", IF_ID_instr, IF_ID_valid); end
        PCWrite = 1'b1; IF_ID_Write = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8) begin errors++; $display("FAIL t2_resume_req got req=%0h addr=%08h exp req=1 addr=00000008", imem.imem_req, imem.imem_addr); end
        tick();
        #1;
        checks++; if (IF_ID_instr !== 32'h1111_1111 || IF_ID_pc4 !== 32'h8 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL t2_deliver got %08h/%08h v=%0h exp 11111111/00000008 v=1", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
    endtask

    task automatic test_redirect_resp();
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL t3_drop_req got %0h exp 0", imem.imem_req); end
        tick();
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("FAIL t3_valid_wait got %0h exp 0", IF_ID_valid); end
        tick();
        imem.imem_rvalid = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin errors++; $display("FAIL t3_next_req got req=%0h addr=%08h exp req=1 addr=00000100", imem.imem_req, imem.imem_addr); end
        tick();
        #1;
        checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0) begin errors++; $display("FAIL t3_discard got %08h v=%0h exp 00000000 v=0", IF_ID_instr, IF_ID_valid); end
    endtask

    task automatic test_redirect_rvalid();
        // Still in REQ at 0x100: grant, then redirect in the rvalid cycle.
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hCAFE_F00D;
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        imem.imem_rvalid = 1'b0; redirect = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200) begin errors++; $display("FAIL t4_next_req got req=%0h addr=%08h exp req=1 addr=00000200", imem.imem_req, imem.imem_addr); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        #1;
        checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("FAIL t4_discard got %0h exp 0", IF_ID_valid); end
    endtask

    task automatic test_redirect_hold();
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h2222_3333;
        tick();
        imem.imem_rvalid = 1'b0;
        tick();
        #1;
        checks++; if (IF_ID_instr !== 32'h2222_3333 || IF_ID_pc4 !== 32'h204 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL t5_loaded got %08h/%08h v=%0h exp 22223333/00000204 v=1", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
        IF_ID_Write = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL t5_req_masked got %0h exp 0", imem.imem_req); end
        tick();
        IF_ID_Write = 1'b1; redirect = 1'b0;
        #1;
        checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0 || IF_ID_pc4 !== 32'h204) begin errors++; $display("FAIL t5_bubble got %08h/%08h v=%0h exp 00000000/00000204 v=0", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
    endtask

    task automatic test_wrap_and_reset();
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL t6_top_req got req=%0h addr=%08h exp req=1 addr=fffffffc", imem.imem_req, imem.imem_addr); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h3333_4444;
        tick();
        imem.imem_rvalid = 1'b0;
        #1;
        checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL t6_wrap_addr got %08h exp 00000000", imem.imem_addr); end
        tick();
        #1;
        checks++; if (IF_ID_instr !== 32'h3333_4444 || IF_ID_pc4 !== 32'h0 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL t6_wrap_ifid got %08h/%08h v=%0h exp 33334444/00000000 v=1", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (IF_ID_valid !== 1'b0 || IF_ID_pc4 !== 32'h0 || IF_ID_instr !== 32'h0 || imem.imem_req !== 1'b0) begin errors++; $display("FAIL t6_async_rst got %08h/%08h v=%0h req=%0h exp 0/0 v=0 req=0", IF_ID_instr, IF_ID_pc4, IF_ID_valid, imem.imem_req); end
        tick();
        rst_n = 1'b1;
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hBADB_AD00;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin errors++; $display("FAIL t6_post_rst_req got req=%0h addr=%08h exp req=1 addr=00000000", imem.imem_req, imem.imem_addr); end
        tick();
        imem.imem_rvalid = 1'b0;
        tick();
        #1;
        checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0) begin errors++; $display("FAIL t6_stray_rvalid got %08h v=%0h exp 00000000 v=0", IF_ID_instr, IF_ID_valid); end
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin errors++; $display("FAIL t6_still_req got req=%0h addr=%08h exp req=1 addr=00000000", imem.imem_req, imem.imem_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_fetch();
        test_load_use();
        test_redirect_resp();
        test_redirect_rvalid();
        test_redirect_hold();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
